// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants and the single-decade next-state rule for the BCD scan counter.
// The decoder downstream relies on BLANK_CODE rendering as all segments off.
package bcd_scan_counter_pkg;

    localparam int                 DIGIT_W    = 4;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
    localparam logic [DIGIT_W-1:0] BCD_MAX    = 4'd9;

    // One decade step: 9 rolls to 0 going up, 0 rolls to 9 going down.
    function automatic logic [DIGIT_W-1:0] bcd_next(input logic [DIGIT_W-1:0] q,
                                                    input logic               up);
        if (up) begin
            return (q == BCD_MAX) ? '0 : q + 4'd1;
        end
        return (q == '0) ? BCD_MAX : q - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: steps on step_in and raises carry_out when the step
// rolls the decade over, so the next decade steps in the same cycle.
module bcd_digit
    import bcd_scan_counter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               step_in,
    input  logic               up,
    output logic [DIGIT_W-1:0] q,
    output logic               carry_out
);

    assign carry_out = step_in & ((up & (q == BCD_MAX)) | (~up & (q == '0)));

    // NOTE: state registers use <= so every flop samples pre-edge values; a
    // blocking = here would let chained logic see half-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (step_in) begin
            q <= bcd_next(q, up);
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-decade BCD up/down counter with a time-multiplexed digit scanner.
// Define BCD_SCAN_LZB_EN to blank leading zeros (data = BLANK_CODE above the top nonzero digit).
module bcd_scan_counter
    import bcd_scan_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        up,
    input  logic                        clr,
    output logic [DIGIT_W-1:0]          data,
    output logic [DIGITS-1:0]           digit_sel,
    output logic [DIGITS*DIGIT_W-1:0]   value,
    output logic                        wrap
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [TICK_W-1:0]  tick_cnt;
    logic               tick_hit;
    logic               step;
    logic [DIGITS:0]    chain;
    logic [DIGIT_W-1:0] digit_q [DIGITS];
    logic [SCAN_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]   scan_idx;
    logic               blank;

    // Step prescaler: clr wins over a coincident step so no wrap can escape.
    assign tick_hit = (tick_cnt == TICK_LAST);
    assign step     = en & tick_hit & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (en) begin
            tick_cnt <= tick_hit ? '0 : tick_cnt + 1'b1;
        end
    end

    assign chain[0] = step;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .step_in   (chain[g]),
            .up        (up),
            .q         (digit_q[g]),
            .carry_out (chain[g+1])
        );
        assign value[g*DIGIT_W +: DIGIT_W] = digit_q[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= chain[DIGITS];
        end
    end

    // Scanner runs freely; en and clr only touch the count path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef BCD_SCAN_LZB_EN
    logic [IDX_W-1:0] top_nz;

    // NOTE: top_nz gets a default before the loop so the block stays purely
    // combinational; leaving any path unassigned would infer a latch.
    always_comb begin
        top_nz = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (digit_q[i] != '0) begin
                top_nz = IDX_W'(i);
            end
        end
    end

    assign blank = (scan_idx > top_nz);
`else
    assign blank = 1'b0;
`endif

    // Both display outputs come from the same index register, so the select
    // and its digit code always change together and only one bit is ever low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            digit_sel <= ~DIGITS'(1);
        end else begin
            data      <= blank ? BLANK_CODE : digit_q[scan_idx];
            digit_sel <= ~(DIGITS'(1) << scan_idx);
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter: an arithmetic reference model pushes the
// expected outputs of every clock edge, a monitor pops and compares on the falling edge.
module tb_bcd_scan_counter;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int MODULUS  = 10000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        up    = 1'b1;
    logic        clr   = 1'b0;
    logic [3:0]  data;
    logic [3:0]  digit_sel;
    logic [15:0] value;
    logic        wrap;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  data;
        logic [3:0]  sel;
        logic        wrap;
    } exp_t;

    exp_t exp_q[$];

    bcd_scan_counter #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .clr       (clr),
        .data      (data),
        .digit_sel (digit_sel),
        .value     (value),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((n / (10 ** i)) % 10);
        end
        return r;
    endfunction

    function automatic logic [3:0] disp_code(input int n, input int i);
`ifdef BCD_SCAN_LZB_EN
        if (i > 0 && n < 10 ** i) begin
            return 4'hF;
        end
`endif
        return 4'((n / (10 ** i)) % 10);
    endfunction

    // Reference model: integer count, enabled-cycle phase, and elapsed cycles for the scan position.
    int m_count;
    int m_phase;
    int m_cycles;

    initial begin
        exp_t       e;
        int         idx;
        logic [3:0] one;
        one = 4'b0001;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_count  = 0;
                m_phase  = 0;
                m_cycles = 0;
                exp_q.delete();
            end else begin
                idx    = (m_cycles / SCAN_DIV) % DIGITS;
                e.data = disp_code(m_count, idx);
                e.sel  = ~(one << idx);
                e.wrap = 1'b0;
                if (clr) begin
                    m_count = 0;
                    m_phase = 0;
                end else if (en) begin
                    if (m_phase == TICK_DIV - 1) begin
                        m_phase = 0;
                        if (up) begin
                            e.wrap  = (m_count == MODULUS - 1);
                            m_count = (m_count + 1) % MODULUS;
                        end else begin
                            e.wrap  = (m_count == 0);
                            m_count = (m_count + MODULUS - 1) % MODULUS;
                        end
                    end else begin
                        m_phase++;
                    end
                end
                m_cycles = (m_cycles + 1) % (SCAN_DIV * DIGITS);
                e.value  = to_bcd(m_count);
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compare away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("onehot", $countones(~digit_sel), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("value", value, e.value);
                    check("data", data, e.data);
                    check("digit_sel", digit_sel, e.sel);
                    check("wrap", wrap, e.wrap);
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_value"}, value, 16'h0000);
        check({tag, "_data"}, data, 4'h0);
        check({tag, "_sel"}, digit_sel, 4'b1110);
        check({tag, "_wrap"}, wrap, 1'b0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        run(1);
        clr = 1'b0;
    endtask

    initial begin
        run(3);
        check_reset("rst");

        // Count up across the first decade carry.
        rst_n = 1'b1;
        en    = 1'b1;
        up    = 1'b1;
        run(40);
        check("ten_steps", value, 16'h0010);

        // Underflow, further decrement, then overflow back.
        do_clr();
        up = 1'b0;
        run(8);
        check("down_two", value, 16'h9998);
        up = 1'b1;
        run(8);
        check("overflow", value, 16'h0000);

        // Freeze mid-prescale, then resume.
        do_clr();
        run(2);
        en = 1'b0;
        run(100);
        en = 1'b1;
        run(6);

        // clr coincident with an underflowing step.
        do_clr();
        up = 1'b0;
        run(3);
        clr = 1'b1;
        run(1);
        clr = 1'b0;
        en  = 1'b0;
        check("clr_step_value", value, 16'h0000);
        check("clr_step_wrap", wrap, 1'b0);

        // Random enable / direction / clear traffic.
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(3) != 0);
            up  = $urandom_range(1);
            clr = ($urandom_range(31) == 0);
            run(1);
        end
        clr = 1'b0;

        // Scan a settled 1234.
        do_clr();
        en = 1'b1;
        up = 1'b1;
        run(1234 * TICK_DIV);
        en = 1'b0;
        run(16);
        check("scan_value", value, 16'h1234);

        // Scan 0045 and 0000 (leading-zero behaviour depends on the build).
        do_clr();
        en = 1'b1;
        run(45 * TICK_DIV);
        en = 1'b0;
        run(16);
        do_clr();
        run(16);

        // Count a little, then asynchronous reset mid-scan.
        en = 1'b1;
        run(30);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
